// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared types and constants for the output-port serializer.
//                Holds the transmit FSM state encoding and the UART framing
//                constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    // Transmit FSM state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // UART frame constants
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   BITS_PER_BYTE        = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;

endpackage : io_pkg
`default_nettype wire

// File: rtl/outport_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : outport_fifo
//  Description : Synchronous word FIFO with a registered head output and a
//                sticky overflow flag. A push while full is accepted only
//                when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module outport_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          Reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_head;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_pop;
    logic                  w_do_push;
    logic [PTR_W-1:0]      w_rd_ptr_next;
    logic [DATA_WIDTH-1:0] w_head_next;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop && !w_empty;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign w_do_push = push && (!w_full || w_do_pop);

    assign w_rd_ptr_next = w_do_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    // The word written this cycle becomes the head when it lands in the slot
    // the read pointer is about to point at (empty, or single word popped).
    assign w_head_next   = (w_do_push && (r_wr_ptr == w_rd_ptr_next)) ?
                           push_data : r_mem[w_rd_ptr_next];

    // Storage array; contents need no reset since count qualifies them.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            r_head   <= w_head_next;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign head     = r_head;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign count    = r_count;

endmodule : outport_fifo
`default_nettype wire

// File: rtl/outport_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : outport_serializer
//  Description : Captures words written to the CPU output port into a small
//                FIFO and shifts each one out as UART-framed bytes, least
//                significant byte first, LSB first within each byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module outport_serializer
    import io_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                          clock,
    input  logic                          Reset,
    input  logic                          OutPortin,
    input  logic [DATA_WIDTH-1:0]         BusMuxOut,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int BYTES  = DATA_WIDTH / BITS_PER_BYTE;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    tx_state_t             r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [2:0]            r_bit_idx;
    logic [BYTE_W-1:0]     r_byte_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;

    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_empty;
    logic                  w_baud_end;
    logic                  w_last_byte;
    logic                  w_pop;

    assign w_baud_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last_byte = (r_byte_idx == BYTE_W'(BYTES - 1));
    // A word is taken from the FIFO when idle, or at the end of the final
    // stop bit so the next word follows without an idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) ||
                    ((r_state == STOP) && w_baud_end && w_last_byte));

    outport_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .Reset     (Reset),
        .push      (OutPortin),
        .push_data (BusMuxOut),
        .pop       (w_pop),
        .head      (w_head),
        .full      (full),
        .empty     (w_empty),
        .overflow  (overflow),
        .count     (count)
    );

    // Frame sequencer: baud timing, bit/byte indexing and registered tx.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= STOP_BIT;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift    <= w_head;
                        r_byte_idx <= '0;
                        r_tx       <= START_BIT;
                        r_state    <= START;
                    end else begin
                        r_tx <= STOP_BIT;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        // Shifting after every bit leaves the next byte in
                        // the low bits once this byte is finished.
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'(BITS_PER_BYTE - 1)) begin
                            r_tx    <= STOP_BIT;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (!w_last_byte) begin
                            r_byte_idx <= r_byte_idx + BYTE_W'(1);
                            r_tx       <= START_BIT;
                            r_state    <= START;
                        end else if (!w_empty) begin
                            r_shift    <= w_head;
                            r_byte_idx <= '0;
                            r_tx       <= START_BIT;
                            r_state    <= START;
                        end else begin
                            r_tx    <= STOP_BIT;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_tx    <= STOP_BIT;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != IDLE) || !w_empty;

endmodule : outport_serializer
`default_nettype wire

// File: tb/tb_outport_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_outport_serializer
//  Description : Directed, self-checking bench for outport_serializer.
//                Serial output is compared cycle by cycle against an
//                independently built UART waveform.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_outport_serializer;

    localparam int CPB        = 16;
    localparam int BIT_SLOT   = CPB;
    localparam int BYTE_CYC   = 10 * CPB;
    localparam int WORD_CYC   = 4 * BYTE_CYC;

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic        OutPortin = 1'b0;
    logic [31:0] BusMuxOut = '0;
    logic        tx;
    logic        busy;
    logic        full;
    logic        overflow;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    outport_serializer #(
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock     (clock),
        .Reset     (Reset),
        .OutPortin (OutPortin),
        .BusMuxOut (BusMuxOut),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        strobe;
        logic [31:0] data;
        logic [2:0]  exp_count;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_tx;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected tx level at cycle i of a word frame (cycle 0 = first start cycle)
    function automatic logic exp_bit(input logic [31:0] w, input int i);
        int b;
        int slot;
        b    = i / BYTE_CYC;
        slot = (i % BYTE_CYC) / BIT_SLOT;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return w[b*8 + slot - 1];
    endfunction

    // Compare tx against one full word frame, starting at cycle offset off.
    task automatic check_word(input logic [31:0] w, input int off);
        int errs;
        int first_bad;
        errs = 0;
        first_bad = -1;
        for (int i = off; i < WORD_CYC; i++) begin
            if (tx !== exp_bit(w, i)) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
            tick();
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL tx_word_%08h actual=%0d_bad_cycles(first=%0d) required=0",
                     w, errs, first_bad);
        end
    endtask

    task automatic do_reset();
        OutPortin = 1'b0;
        Reset     = 1'b1;
        tick();
        Reset     = 1'b0;
    endtask

    initial begin
        // Six strobes into an idle device: head pops at the next edge.
        vecs[0] = '{1'b1, 32'h11223344, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'h55667788, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h99AABBCC, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'hDDEEFF00, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h13579BDF, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'hDEADBEEF, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h00000000, 3'd4, 1'b1, 1'b1, 1'b0};

        // ---- Reset state
        tick();
        Reset = 1'b1;
        tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        Reset = 1'b0;
        tick();

        // ---- Single word: capture latency and full frame
        OutPortin = 1'b1;
        BusMuxOut = 32'hA5C30F01;
        tick();
        OutPortin = 1'b0;
        check("single_count", 32'(count), 32'd1);
        check("single_tx_idle", 32'(tx), 32'd1);
        tick();
        check("single_tx_start", 32'(tx), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        check_word(32'hA5C30F01, 0);
        check("single_busy_end", 32'(busy), 32'd0);
        check("single_count_end", 32'(count), 32'd0);

        // ---- Five consecutive strobes: back-to-back words, no overflow
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    OutPortin = 1'b1;
                    BusMuxOut = 32'(i);
                    tick();
                    check($sformatf("five_count_%0d", i), 32'(count),
                          (i == 1) ? 32'd1 : 32'(i - 1));
                end
                OutPortin = 1'b0;
                check("five_full", 32'(full), 32'd1);
                check("five_ovf", 32'(overflow), 32'd0);
            end
            begin
                tick();
                tick();
                for (int i = 1; i <= 5; i++) check_word(32'(i), 0);
            end
        join
        check("five_busy_end", 32'(busy), 32'd0);
        check("five_ovf_end", 32'(overflow), 32'd0);

        // ---- Six strobes: table-driven occupancy/overflow, then serial data
        for (int v = 0; v < 7; v++) begin
            OutPortin = vecs[v].strobe;
            BusMuxOut = vecs[v].data;
            tick();
            check($sformatf("six_count_%0d", v), 32'(count), 32'(vecs[v].exp_count));
            check($sformatf("six_full_%0d", v), 32'(full), 32'(vecs[v].exp_full));
            check($sformatf("six_ovf_%0d", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            check($sformatf("six_tx_%0d", v), 32'(tx), 32'(vecs[v].exp_tx));
        end
        OutPortin = 1'b0;
        check_word(vecs[0].data, 5);
        for (int v = 1; v < 5; v++) check_word(vecs[v].data, 0);
        check("six_busy_end", 32'(busy), 32'd0);
        check("six_ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        check("six_ovf_cleared", 32'(overflow), 32'd0);

        // ---- Push while full, coinciding with a pop
        for (int i = 0; i < 5; i++) begin
            OutPortin = 1'b1;
            BusMuxOut = 32'h0F0F0000 + 32'(i);
            tick();
        end
        OutPortin = 1'b0;
        check("fp_full", 32'(full), 32'd1);
        for (int i = 0; i < WORD_CYC - 4; i++) tick();
        check("fp_count_pre", 32'(count), 32'd4);
        OutPortin = 1'b1;
        BusMuxOut = 32'hCAFEF00D;
        tick();
        OutPortin = 1'b0;
        check("fp_count", 32'(count), 32'd4);
        check("fp_full_post", 32'(full), 32'd1);
        check("fp_ovf", 32'(overflow), 32'd0);
        check("fp_tx_next_start", 32'(tx), 32'd0);

        // ---- Reset in the middle of a frame
        do_reset();
        OutPortin = 1'b1;
        BusMuxOut = 32'h12345678;
        tick();
        BusMuxOut = 32'h9ABCDEF0;
        tick();
        OutPortin = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        Reset = 1'b1;
        tick();
        check("mid_tx", 32'(tx), 32'd1);
        check("mid_count", 32'(count), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        Reset = 1'b0;
        tick();
        check("mid_tx_idle", 32'(tx), 32'd1);
        OutPortin = 1'b1;
        BusMuxOut = 32'h0BADC0DE;
        tick();
        OutPortin = 1'b0;
        tick();
        check_word(32'h0BADC0DE, 0);
        check("mid_busy_end", 32'(busy), 32'd0);

        // ---- All-ones then all-zeros payload
        OutPortin = 1'b1;
        BusMuxOut = 32'hFFFFFFFF;
        tick();
        BusMuxOut = 32'h00000000;
        tick();
        OutPortin = 1'b0;
        check_word(32'hFFFFFFFF, 0);
        check_word(32'h00000000, 0);
        check("ones_zeros_busy_end", 32'(busy), 32'd0);
        check("ones_zeros_tx_idle", 32'(tx), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_outport_serializer
`default_nettype wire
